// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between an instruction cache and a data cache.
// One line transaction at a time: IDLE -> MEM (strobe until m_rdy or timeout) -> RESP (ack) -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

    state_e            state_q,   state_d;
    side_e             winner_q,  winner_d;
    side_e             last_q,    last_d;
    side_e             grant_side;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              we_q,      we_d;
    logic [LINE_W-1:0] wdata_q,   wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              err_q,     err_d;

    // On a tie the side not granted last wins; a lone requester always wins.
    always_comb begin
        if (i_req && d_req) begin
            grant_side = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
            grant_side = SIDE_D;
        end else begin
            grant_side = SIDE_I;
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    winner_d = grant_side;
                    last_d   = grant_side;
                    cnt_d    = '0;
                    state_d  = MEM;
                    if (grant_side == SIDE_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_we ? d_wdata : '0;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            MEM: begin
                if (m_rdy) begin
                    if (!we_q) begin
                        if (winner_q == SIDE_D) d_rdata_d = m_rdata;
                        else                    i_rdata_d = m_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and only evaluated on posedge clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            winner_q  <= SIDE_I;
            last_q    <= SIDE_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Strobes and acks decode directly from registered state, so they are glitch-free and mutually exclusive.
    assign m_re    = (state_q == MEM) && !we_q;
    assign m_we    = (state_q == MEM) &&  we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_ack   = (state_q == RESP) && (winner_q == SIDE_I);
    assign d_ack   = (state_q == RESP) && (winner_q == SIDE_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory answers strobes after a programmable delay,
// and a scoreboard of expected (side, rdata) pairs is checked on every ack.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int LINE_W = 64;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              i_ack, d_ack;
    logic              m_re, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_rdy;
    logic              busy, err;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              side;   // 1 = D, 0 = I
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t              sb[$];
    logic [LINE_W-1:0] mem [logic [ADDR_W-1:0]];
    int                checks   = 0;
    int                failures = 0;
    int                mem_delay = 1;      // 0 = memory never answers
    int                strobe_cnt = 0;
    int                last_len = 0;
    logic              stray = 1'b0;
    logic [LINE_W-1:0] stray_data = '0;
    logic [LINE_W-1:0] exp_i = '0;
    logic [LINE_W-1:0] exp_d = '0;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {16'h1111 ^ a16, 16'h2222 ^ a16, 16'h3333 ^ a16, 16'h4444 ^ a16};
    endfunction

    function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return line_of(a);
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: m_rdy rises in the mem_delay-th strobe cycle; stray pulses only while idle.
    always @(negedge clk) begin
        if (m_re || m_we) begin
            strobe_cnt++;
            if (strobe_cnt == mem_delay) begin
                m_rdy = 1'b1;
                if (m_re) m_rdata = mem_read(m_addr);
                else      mem[m_addr] = m_wdata;
            end else begin
                m_rdy   = 1'b0;
                m_rdata = 64'hBADB_ADBA_DBAD_BADB;
            end
        end else begin
            if (strobe_cnt != 0) last_len = strobe_cnt;
            strobe_cnt = 0;
            m_rdy      = stray;
            m_rdata    = stray_data;
        end
    end

    // Ack monitor: every ack must match the oldest scoreboard entry.
    always @(negedge clk) begin
        chk("strobe_exclusive", 64'(m_re && m_we), 64'd0);
        if (i_ack || d_ack) begin
            exp_t e;
            chk("ack_exclusive", 64'(i_ack && d_ack), 64'd0);
            chk("ack_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack_side", 64'(d_ack), 64'(e.side));
                chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
            end
        end
    end

    task automatic run_txns(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while ((i_req || d_req || busy) && n < budget) begin
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({tag, "_in_budget"}, 64'(n < budget), 64'd1);
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_re"},    64'(m_re),  64'd0);
        chk({tag, "_m_we"},    64'(m_we),  64'd0);
        chk({tag, "_i_ack"},   64'(i_ack), 64'd0);
        chk({tag, "_d_ack"},   64'(d_ack), 64'd0);
        chk({tag, "_busy"},    64'(busy),  64'd0);
        chk({tag, "_err"},     64'(err),   64'd0);
        chk({tag, "_m_addr"},  64'(m_addr), 64'd0);
        chk({tag, "_m_wdata"}, m_wdata, 64'd0);
        chk({tag, "_i_rdata"}, i_rdata, 64'd0);
        chk({tag, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdy = 1'b0; m_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");

        // Simultaneous requests right after reset: D wins the first tie, then I
        @(negedge clk);
        rst_n = 1'b1; mem_delay = 1;
        i_addr = 14'h0040; d_addr = 14'h0300; d_we = 1'b0;
        sb.push_back('{1'b1, line_of(14'h0300)});
        sb.push_back('{1'b0, line_of(14'h0040)});
        i_req = 1'b1; d_req = 1'b1;
        run_txns("tie1", 30);
        exp_d = line_of(14'h0300);
        exp_i = line_of(14'h0040);

        // Single I read at 0x0010 with a 4-cycle memory
        mem_delay = 4;
        i_addr = 14'h0010;
        sb.push_back('{1'b0, line_of(14'h0010)});
        i_req = 1'b1;
        @(negedge clk);
        chk("iread_m_re", 64'(m_re), 64'd1);
        chk("iread_m_addr", 64'(m_addr), 64'h0010);
        run_txns("iread", 30);
        chk("iread_strobe_len", 64'(last_len), 64'd4);
        exp_i = line_of(14'h0010);

        // D write-back: d_rdata must stay at its last read value
        mem_delay = 3;
        d_addr = 14'h0200; d_we = 1'b1; d_wdata = 64'hDEAD_BEEF_0123_4567;
        sb.push_back('{1'b1, exp_d});
        d_req = 1'b1;
        @(negedge clk);
        chk("dwr_m_we", 64'(m_we), 64'd1);
        chk("dwr_m_re", 64'(m_re), 64'd0);
        chk("dwr_m_addr", 64'(m_addr), 64'h0200);
        chk("dwr_m_wdata", m_wdata, 64'hDEAD_BEEF_0123_4567);
        run_txns("dwr", 30);
        chk("dwr_strobe_len", 64'(last_len), 64'd3);
        chk("dwr_mem_written", mem_read(14'h0200), 64'hDEAD_BEEF_0123_4567);
        d_we = 1'b0;

        // Second tie with D granted last: I first, then D reads back the written line
        mem_delay = 2;
        i_addr = 14'h0123; d_addr = 14'h0200;
        sb.push_back('{1'b0, line_of(14'h0123)});
        sb.push_back('{1'b1, 64'hDEAD_BEEF_0123_4567});
        i_req = 1'b1; d_req = 1'b1;
        run_txns("tie2", 30);
        exp_i = line_of(14'h0123);
        exp_d = 64'hDEAD_BEEF_0123_4567;

        // Timeout: memory never answers, strobe lasts exactly TMO cycles, err sticks
        mem_delay = 0;
        i_addr = 14'h0050;
        sb.push_back('{1'b0, exp_i});
        i_req = 1'b1;
        run_txns("tmo", 40);
        chk("tmo_strobe_len", 64'(last_len), 64'(TMO));
        chk("tmo_err", 64'(err), 64'd1);
        mem_delay = 2;
        d_addr = 14'h0060;
        sb.push_back('{1'b1, line_of(14'h0060)});
        d_req = 1'b1;
        run_txns("after_tmo", 30);
        exp_d = line_of(14'h0060);
        chk("err_sticky", 64'(err), 64'd1);

        // Stray m_rdy while idle changes nothing
        stray = 1'b1; stray_data = 64'hFFFF_0000_FFFF_0000;
        repeat (3) begin
            @(negedge clk);
            chk("stray_busy", 64'(busy), 64'd0);
        end
        stray = 1'b0;
        @(negedge clk);
        chk("stray_i_rdata", i_rdata, exp_i);
        chk("stray_d_rdata", d_rdata, exp_d);

        // Reset two cycles into MEM of a read aborts it without an ack
        mem_delay = 0;
        i_addr = 14'h0070;
        i_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_mem", 64'(m_re), 64'd1);
        rst_n = 1'b0; i_req = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        exp_i = '0; exp_d = '0;

        // Normal service after the abort
        mem_delay = 2;
        i_addr = 14'h0080;
        sb.push_back('{1'b0, line_of(14'h0080)});
        i_req = 1'b1;
        run_txns("post_abort", 30);
        chk("post_abort_err", 64'(err), 64'd0);
        chk("post_abort_d_rdata", d_rdata, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, line-address width.
REQ-002 Parameter LINE_W, default 64, cache-line width (four 16-bit words).
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for m_rdy per transaction.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_req  input  1  instruction-cache line read request; held until i_ack.
REQ-007 i_addr  input  ADDR_W  instruction line address.
REQ-008 i_rdata  output  LINE_W  returned instruction line.
REQ-009 i_ack  output  1  one-cycle completion pulse to I-side.
REQ-010 d_req  input  1  data-cache request (fill or dirty write-back); held until d_ack.
REQ-011 d_we  input  1  1 = write-back, 0 = fill.
REQ-012 d_addr  input  ADDR_W  data line address.
REQ-013 d_wdata  input  LINE_W  dirty line to write.
REQ-014 d_rdata  output  LINE_W  returned data line.
REQ-015 d_ack  output  1  one-cycle completion pulse to D-side.
REQ-016 m_re / m_we  output  1 each  main-memory read / write strobe.
REQ-017 m_addr  output  ADDR_W; m_wdata  output  LINE_W; m_rdata  input  LINE_W.
REQ-018 m_rdy  input  1  memory completion; m_rdata valid in the same cycle for reads.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, MEM, RESP.
REQ-022 IDLE: if any req is high at a clock edge, the arbiter SHALL register winner, addr, we, wdata and enter MEM; otherwise it SHALL remain in IDLE.
REQ-023 Arbitration SHALL be round-robin: on a tie, grant goes to the side not granted last; single requester always wins.
REQ-024 MEM: m_re (read) or m_we (write) SHALL be high, with m_addr/m_wdata driven from the registered values, stable for the whole state.
REQ-025 MEM: on m_rdy=1, read data SHALL be captured into the winner's rdata register, strobes SHALL drop, and the FSM SHALL enter RESP.
REQ-026 RESP: exactly the winner's ack SHALL be high for one cycle, then the FSM SHALL return to IDLE.
REQ-027 Minimum latency: request sampled at cycle G, m_rdy at G+1, ack at G+2; next grant earliest at G+3.
REQ-028 Requesters SHALL keep req low in the cycle after ack; requester input changes during MEM/RESP SHALL be ignored.
REQ-029 m_rdy outside MEM SHALL be ignored.
REQ-030 A write SHALL leave d_rdata unchanged; i_rdata/d_rdata SHALL hold their last read value until the next read for that side completes.
REQ-031 In MEM, a wait counter SHALL increment each cycle without m_rdy; when it reaches TIMEOUT, strobes SHALL drop, err SHALL set, and the FSM SHALL enter RESP (ack issued, rdata unchanged).
REQ-032 err SHALL stay high until reset.
REQ-033 At most one of m_re, m_we SHALL ever be high; at most one ack SHALL be high per cycle.

Reset
REQ-034 With rst_n low at a clock edge: state IDLE; m_re, m_we, i_ack, d_ack, busy, err = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; wait counter 0; last-granted = I (D wins first tie).
REQ-035 Reset asserted mid-transaction SHALL abort it without issuing ack; memory strobes SHALL be low from the next cycle.

Verification
REQ-036 Single I read, addr 0x0010, memory m_rdy 4 cycles after m_re -> m_re for 4 cycles, i_rdata = line at 0x0010, i_ack one cycle, d_ack never.
REQ-037 i_req and d_req both high first cycle after reset -> D granted first, then I; second round of simultaneous requests -> I first.
REQ-038 D write-back, d_addr 0x0200, d_wdata 0xDEAD_BEEF_0123_4567 -> m_we with those values until m_rdy, d_ack pulse, d_rdata unchanged.
REQ-039 m_rdy held low, TIMEOUT=8 -> strobe high exactly 8 cycles, err=1, ack pulse, err still 1 after later transactions.
REQ-040 rst_n low 2 cycles into MEM of a read -> no ack, m_re low next cycle, all outputs at REQ-034 values; next request serviced normally.
REQ-041 Stray m_rdy pulses while IDLE -> no state change, no ack, rdata unchanged.
